// File: rtl/strait_bist_pkg.sv
// Shared types and helpers for the STRAIT array BIST controller:
// FSM state encoding, default LFSR/MISR polynomials and seed, and the Galois shift step.
package strait_bist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      CAPTURE,
      FLUSH,
      COMPARE,
      DONE
   } state_e;

   localparam logic [31:0] DEF_LFSR_POLY = 32'h8020_0003;
   localparam logic [31:0] DEF_LFSR_SEED = 32'hACE1_2024;
   localparam logic [31:0] DEF_MISR_POLY = 32'h04C1_1DB7;

   // Widest register the step helper supports; callers zero-extend in and truncate out,
   // which is exact because a right shift never moves bits above the caller's width.
   localparam int GALOIS_MAX_W = 64;

   function automatic logic [GALOIS_MAX_W-1:0] galois_step(
      input logic [GALOIS_MAX_W-1:0] x,
      input logic [GALOIS_MAX_W-1:0] poly
   );
      return x[0] ? ((x >> 1) ^ poly) : (x >> 1);
   endfunction

endpackage

// File: rtl/strait_misr.sv
// Multiple-input signature register: Galois-stepped accumulator that folds one data word per
// enabled cycle; clr has priority and zeroes the signature.
module strait_misr
   import strait_bist_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] POLY       = DATA_WIDTH'(DEF_MISR_POLY)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] sig
);

   logic [DATA_WIDTH-1:0] sig_q, sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clr) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = DATA_WIDTH'(galois_step(GALOIS_MAX_W'(sig_q), GALOIS_MAX_W'(POLY))) ^ din;
      end
   end

   // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sig_q <= '0;
      else     sig_q <= sig_d;
   end

   assign sig = sig_q;

endmodule

// File: rtl/strait_bist_ctrl.sv
// STRAIT BIST controller: shifts LFSR patterns into the array's P chains, pulses MAC captures,
// compacts the per-row scan outputs into a MISR and compares the final signature with a golden value.
module strait_bist_ctrl
   import strait_bist_pkg::*;
#(
   parameter int                    N            = 16,
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    NUM_PATTERNS = 8,
   parameter logic [DATA_WIDTH-1:0] LFSR_POLY    = DATA_WIDTH'(DEF_LFSR_POLY),
   parameter logic [DATA_WIDTH-1:0] LFSR_SEED    = DATA_WIDTH'(DEF_LFSR_SEED),
   parameter logic [DATA_WIDTH-1:0] MISR_POLY    = DATA_WIDTH'(DEF_MISR_POLY)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   golden_sig,
   input  logic [N*DATA_WIDTH-1:0] scan_out_p,
   output logic                    scan_en,
   output logic [N*DATA_WIDTH-1:0] scan_in_p,
   output logic [N*DATA_WIDTH-1:0] test_a,
   output logic [N*DATA_WIDTH-1:0] test_w,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic [DATA_WIDTH-1:0]   signature
);

   localparam int SH_W  = $clog2(N);
   localparam int PAT_W = $clog2(NUM_PATTERNS + 1);
   localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(N - 1);
   localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PATTERNS - 1);

   function automatic logic [DATA_WIDTH-1:0] rotl(input logic [DATA_WIDTH-1:0] x, input int r);
      int s;
      s = r % DATA_WIDTH;
      if (s == 0) return x;
      return (x << s) | (x >> (DATA_WIDTH - s));
   endfunction

   state_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   lfsr_q, lfsr_d;
   logic [SH_W-1:0]         sh_cnt_q, sh_cnt_d;
   logic [PAT_W-1:0]        pat_cnt_q, pat_cnt_d;
   logic                    pass_q, pass_d;
   logic                    scan_en_q, scan_en_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [N*DATA_WIDTH-1:0] scan_in_q, scan_in_d;
   logic [N*DATA_WIDTH-1:0] test_a_q, test_a_d;
   logic [N*DATA_WIDTH-1:0] test_w_q, test_w_d;
   logic                    misr_clr, misr_en;
   logic [DATA_WIDTH-1:0]   lane_xor;
   logic [DATA_WIDTH-1:0]   sig;

   always_comb begin
      lane_xor = '0;
      for (int m = 0; m < N; m++) lane_xor ^= scan_out_p[m*DATA_WIDTH +: DATA_WIDTH];
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      sh_cnt_d  = sh_cnt_q;
      pat_cnt_d = pat_cnt_q;
      pass_d    = pass_q;
      misr_clr  = 1'b0;
      misr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SHIFT;
               lfsr_d    = LFSR_SEED;
               misr_clr  = 1'b1;
               pass_d    = 1'b0;
               pat_cnt_d = '0;
               sh_cnt_d  = '0;
            end
         end
         SHIFT: begin
            lfsr_d  = DATA_WIDTH'(galois_step(GALOIS_MAX_W'(lfsr_q), GALOIS_MAX_W'(LFSR_POLY)));
            // The first pattern only loads the chain; what comes out is reset residue.
            misr_en = (pat_cnt_q != '0);
            if (sh_cnt_q == SH_LAST) begin
               sh_cnt_d = '0;
               state_d  = CAPTURE;
            end else begin
               sh_cnt_d = sh_cnt_q + SH_W'(1);
            end
         end
         CAPTURE: begin
            pat_cnt_d = pat_cnt_q + PAT_W'(1);
            state_d   = (pat_cnt_q == PAT_LAST) ? FLUSH : SHIFT;
         end
         FLUSH: begin
            misr_en = 1'b1;
            if (sh_cnt_q == SH_LAST) begin
               sh_cnt_d = '0;
               state_d  = COMPARE;
            end else begin
               sh_cnt_d = sh_cnt_q + SH_W'(1);
            end
         end
         COMPARE: begin
            pass_d  = (sig == golden_sig);
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with state_q once registered.
   always_comb begin
      scan_en_d = (state_d == SHIFT) || (state_d == FLUSH);
      busy_d    = state_d inside {SHIFT, CAPTURE, FLUSH, COMPARE};
      done_d    = (state_d == DONE);
      scan_in_d = '0;
      test_a_d  = '0;
      test_w_d  = '0;
      for (int m = 0; m < N; m++) begin
         if (state_d == SHIFT) scan_in_d[m*DATA_WIDTH +: DATA_WIDTH] = rotl(lfsr_d, m);
         if (state_d == CAPTURE) begin
            test_a_d[m*DATA_WIDTH +: DATA_WIDTH] = ~rotl(lfsr_d, m);
            test_w_d[m*DATA_WIDTH +: DATA_WIDTH] = rotl(lfsr_d, m) ^ LFSR_SEED;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         lfsr_q    <= '0;
         sh_cnt_q  <= '0;
         pat_cnt_q <= '0;
         pass_q    <= 1'b0;
         scan_en_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         scan_in_q <= '0;
         test_a_q  <= '0;
         test_w_q  <= '0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         sh_cnt_q  <= sh_cnt_d;
         pat_cnt_q <= pat_cnt_d;
         pass_q    <= pass_d;
         scan_en_q <= scan_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         scan_in_q <= scan_in_d;
         test_a_q  <= test_a_d;
         test_w_q  <= test_w_d;
      end
   end

   strait_misr #(
      .DATA_WIDTH (DATA_WIDTH),
      .POLY       (MISR_POLY)
   ) u_misr (
      .clk (clk),
      .rst (rst),
      .clr (misr_clr),
      .en  (misr_en),
      .din (lane_xor),
      .sig (sig)
   );

   assign scan_en   = scan_en_q;
   assign scan_in_p = scan_in_q;
   assign test_a    = test_a_q;
   assign test_w    = test_w_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign signature = sig;

endmodule

// File: tb/tb_strait_bist_ctrl.sv
// Self-checking bench for strait_bist_ctrl (N=4, 32-bit lanes, 2 patterns): a run-position model
// predicts every output each cycle, and directed scenarios pin the model with literal expectations.
module tb_strait_bist_ctrl;

   localparam int N    = 4;
   localparam int DW   = 32;
   localparam int NP   = 2;
   localparam int LW   = N * DW;
   localparam logic [31:0] SEED  = 32'hACE1_2024;
   localparam logic [31:0] LPOLY = 32'h8020_0003;
   localparam logic [31:0] MPOLY = 32'h04C1_1DB7;
   localparam logic [31:0] SIG3  = 32'h0343_CDC1;  // eight folds of 1 into a zero MISR
   localparam int RUN_LEN  = NP * (N + 1) + N + 1;
   localparam int DONE_CYC = RUN_LEN + 1;

   typedef logic [LW-1:0] vec_t;
   typedef enum int {K_IDLE, K_SHIFT, K_CAPT, K_FLUSH, K_CMP, K_DONE} kind_e;

   logic          clk, rst, start;
   logic [DW-1:0] golden_sig;
   vec_t          scan_out_p, scan_in_p, test_a, test_w;
   logic          scan_en, busy, done, pass;
   logic [DW-1:0] signature;

   int n_checks = 0;
   int n_errors = 0;

   strait_bist_ctrl #(.N(N), .DATA_WIDTH(DW), .NUM_PATTERNS(NP)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .golden_sig (golden_sig),
      .scan_out_p (scan_out_p),
      .scan_en    (scan_en),
      .scan_in_p  (scan_in_p),
      .test_a     (test_a),
      .test_w     (test_w),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .signature  (signature)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input vec_t act, input vec_t exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] gstep(input logic [31:0] x, input logic [31:0] poly);
      return x[0] ? ((x >> 1) ^ poly) : (x >> 1);
   endfunction

   function automatic logic [31:0] rotl32(input logic [31:0] x, input int r);
      int s;
      s = r % 32;
      if (s == 0) return x;
      return (x << s) | (x >> (32 - s));
   endfunction

   function automatic logic [31:0] lfsr_after(input int k);
      logic [31:0] x;
      x = SEED;
      for (int i = 0; i < k; i++) x = gstep(x, LPOLY);
      return x;
   endfunction

   // Position c counts cycles since start was accepted (0 = idle).
   function automatic kind_e kind_of(input int c);
      int p, o;
      if (c == 0) return K_IDLE;
      if (c == DONE_CYC) return K_DONE;
      p = (c - 1) / (N + 1);
      o = (c - 1) % (N + 1);
      if (p < NP) return (o < N) ? K_SHIFT : K_CAPT;
      return (o < N) ? K_FLUSH : K_CMP;
   endfunction

   function automatic logic compacts(input int c);
      return (kind_of(c) == K_SHIFT && (c - 1) / (N + 1) > 0) || kind_of(c) == K_FLUSH;
   endfunction

   function automatic vec_t exp_scan_in(input int c);
      vec_t v;
      v = '0;
      if (kind_of(c) == K_SHIFT)
         for (int m = 0; m < N; m++)
            v[m*DW +: DW] = rotl32(lfsr_after(((c - 1) / (N + 1)) * N + (c - 1) % (N + 1)), m);
      return v;
   endfunction

   function automatic vec_t exp_test(input int c, input logic is_w);
      vec_t v;
      logic [31:0] l;
      v = '0;
      if (kind_of(c) == K_CAPT) begin
         l = lfsr_after(((c - 1) / (N + 1) + 1) * N);
         for (int m = 0; m < N; m++)
            v[m*DW +: DW] = is_w ? (rotl32(l, m) ^ SEED) : ~rotl32(l, m);
      end
      return v;
   endfunction

   function automatic logic [31:0] xor_lanes(input vec_t v);
      logic [31:0] x;
      x = '0;
      for (int m = 0; m < N; m++) x ^= v[m*DW +: DW];
      return x;
   endfunction

   int          m_cyc;
   logic [31:0] m_misr;
   logic        m_pass;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cyc  <= 0;
         m_misr <= '0;
         m_pass <= 1'b0;
      end else if (m_cyc == 0) begin
         if (start) begin
            m_cyc  <= 1;
            m_misr <= '0;
            m_pass <= 1'b0;
         end
      end else begin
         if (compacts(m_cyc)) m_misr <= gstep(m_misr, MPOLY) ^ xor_lanes(scan_out_p);
         if (kind_of(m_cyc) == K_CMP) m_pass <= (m_misr == golden_sig);
         m_cyc <= (kind_of(m_cyc) == K_DONE) ? 0 : m_cyc + 1;
      end
   end

   // ---------------- behavioural 4x4 array (P chains + MAC on capture) ----------------
   logic [DW-1:0] arr [N][N];
   vec_t          arr_out, drv;
   int            cur_mode;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) arr[r][c] <= '0;
      end else if (scan_en) begin
         for (int r = 0; r < N; r++) begin
            arr[r][0] <= scan_in_p[r*DW +: DW];
            for (int c = 1; c < N; c++) arr[r][c] <= arr[r][c-1];
         end
      end else begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               arr[r][c] <= arr[r][c] + test_a[r*DW +: DW] * test_w[c*DW +: DW];
      end
   end

   always_comb begin
      arr_out = '0;
      for (int r = 0; r < N; r++) arr_out[r*DW +: DW] = arr[r][N-1];
   end

   assign scan_out_p = (cur_mode == 3) ? arr_out : drv;

   // ---------------- per-cycle compare ----------------
   logic chk_en;
   int   done_seen = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("scan_en", vec_t'(scan_en),
               vec_t'(kind_of(m_cyc) == K_SHIFT || kind_of(m_cyc) == K_FLUSH));
         check("busy", vec_t'(busy), vec_t'(kind_of(m_cyc) inside {K_SHIFT, K_CAPT, K_FLUSH, K_CMP}));
         check("done", vec_t'(done), vec_t'(kind_of(m_cyc) == K_DONE));
         check("pass", vec_t'(pass), vec_t'(m_pass));
         check("signature", vec_t'(signature), vec_t'(m_misr));
         check("scan_in_p", scan_in_p, exp_scan_in(m_cyc));
         check("test_a", test_a, exp_test(m_cyc, 1'b0));
         check("test_w", test_w, exp_test(m_cyc, 1'b1));
         if (done === 1'b1) done_seen <= done_seen + 1;
      end
   end

   // ---------------- stimulus ----------------
   logic [RUN_LEN-1:0] seq;
   int                 busy_cnt;
   logic [63:0]        first_lanes;

   // inject: 0 none, 1 start pulses while busy and in DONE, 2 reset in the first CAPTURE
   task automatic do_run(input int mode, input logic [31:0] gold, input int inject);
      cur_mode   = mode;
      golden_sig = gold;
      drv        = (mode == 2) ? vec_t'(1) : '0;
      seq        = '0;
      busy_cnt   = 0;
      start      = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      for (int c = 1; c <= DONE_CYC; c++) begin
         if (c <= RUN_LEN) seq = {seq[RUN_LEN-2:0], scan_en};
         busy_cnt += int'(busy);
         if (c == 1) first_lanes = scan_in_p[63:0];
         if (mode == 1) drv = (c <= N) ? '1 : '0;
         start = (inject == 1 && (c == 2 || c == DONE_CYC));
         if (inject == 2 && c == N + 1) begin
            rst = 1'b1;
            #1;
            check("rst_scan_en", vec_t'(scan_en), vec_t'(0));
            check("rst_busy", vec_t'(busy), vec_t'(0));
            check("rst_pass", vec_t'(pass), vec_t'(0));
            @(posedge clk); #2;
            rst = 1'b0;
            drv = '0;
            return;
         end
         @(posedge clk); #2;
      end
      start = 1'b0;
      drv   = '0;
   endtask

   int          done_base;
   logic [31:0] gold6;

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      golden_sig = '0;
      drv        = '0;
      cur_mode   = 0;
      chk_en     = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst    = 1'b0;
      chk_en = 1'b1;

      check("reset_scan_en", vec_t'(scan_en), vec_t'(0));
      check("reset_busy", vec_t'(busy), vec_t'(0));
      check("reset_pass", vec_t'(pass), vec_t'(0));
      check("reset_signature", vec_t'(signature), vec_t'(0));
      check("reset_scan_in", scan_in_p, vec_t'(0));

      // 1: sequence and first shifted pattern
      do_run(0, 32'h0, 0);
      check("seq_scan_en", vec_t'(seq), vec_t'(15'b111101111011110));
      check("seq_busy_cycles", vec_t'(busy_cnt), vec_t'(15));
      check("seq_lane0_first", vec_t'(first_lanes[31:0]), vec_t'(32'hACE1_2024));
      check("seq_lane1_first", vec_t'(first_lanes[63:32]), vec_t'(32'h59C2_4049));

      // 2: first-pattern output is masked
      do_run(1, 32'h0, 0);
      check("mask_signature", vec_t'(signature), vec_t'(0));
      check("mask_pass", vec_t'(pass), vec_t'(1));

      // 3: constant lane-0 compaction against a hand value
      do_run(2, SIG3, 0);
      check("comp_signature", vec_t'(signature), vec_t'(SIG3));
      check("comp_pass", vec_t'(pass), vec_t'(1));
      do_run(2, SIG3 ^ 32'h1, 0);
      check("comp_flip_pass", vec_t'(pass), vec_t'(0));

      // 4: start while busy or in DONE is ignored
      done_base = done_seen;
      do_run(0, 32'h0, 1);
      repeat (3) begin
         @(posedge clk); #2;
      end
      check("busy_start_done_pulses", vec_t'(done_seen - done_base), vec_t'(1));
      check("busy_start_idle", vec_t'(busy), vec_t'(0));

      // 5: reset in CAPTURE, then a clean rerun of scenario 3
      do_run(2, SIG3, 2);
      do_run(2, SIG3, 0);
      check("rerun_signature", vec_t'(signature), vec_t'(SIG3));
      check("rerun_pass", vec_t'(pass), vec_t'(1));

      // 6: closed loop through the array model, twice from the same seed
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      do_run(3, 32'h0, 0);
      gold6 = m_misr;
      do_run(3, gold6, 0);
      check("loop_signature", vec_t'(signature), vec_t'(gold6));
      check("loop_pass", vec_t'(pass), vec_t'(1));

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
